// File: rtl/icache.sv
// Direct-mapped, one-word-per-block, read-only instruction cache with a blocking single-word fill.
// Define ICACHE_FILL_FWD_EN to forward the fill word to the fetch port on the returning cycle.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t           state, nxt_state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [29:0]      miss_word;

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             hit, fill;
  logic             unused_offset;

  assign idx           = imemaddr[IDX_W+1:2];
  assign tag           = imemaddr[31:IDX_W+2];
  assign miss_idx      = miss_word[IDX_W-1:0];
  assign miss_tag      = miss_word[29:IDX_W];
  assign unused_offset = ^imemaddr[1:0];

  assign hit  = imemREN && valid[idx] && (tags[idx] == tag);
  assign fill = (state == MISS) && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_word <= '0;
      valid     <= '0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && imemREN && !hit) miss_word <= imemaddr[31:2];
      if (fill) valid[miss_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

  always_comb begin
    nxt_state = state;
    ihit      = 1'b0;
    imemload  = '0;
    iREN      = 1'b0;
    iaddr     = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data[idx];
        end else if (imemREN) begin
          nxt_state = MISS;
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = {miss_word, 2'b00};
        if (!iwait) begin
          nxt_state = IDLE;
`ifdef ICACHE_FILL_FWD_EN
          if (imemREN && imemaddr[31:2] == miss_word) begin
            ihit     = 1'b1;
            imemload = iload;
          end
`endif
        end
      end
      default: nxt_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a word-addressed line model plus a latency-programmable memory.
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks = 0;
  int failures = 0;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  // Reference: per-set remembered word address + data, and one outstanding fill.
  bit          lv [16];
  logic [31:0] la [16];
  logic [31:0] ld [16];
  bit          busy;
  logic [31:0] fa;
  int          mcnt;
  int          mem_lat;
  bit          rand_lat;
  logic        e_hit, e_ren;
  logic [31:0] e_load, e_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h2008_0001;
  endfunction

  function automatic logic [65:0] obs();
    return {ihit, iREN, imemload, iaddr};
  endfunction

  function automatic logic [65:0] expv();
    return {e_hit, e_ren, e_load, e_addr};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) lv[i] = 0;
    busy = 0;
    mcnt = 0;
  endtask

  task automatic drive(input logic ren, input logic [31:0] a);
    int i;
    logic [31:0] w;
    imemREN  = ren;
    imemaddr = a;
    w = {a[31:2], 2'b00};
    i = int'(a[5:2]);
    if (busy) begin
      iwait  = (mcnt < mem_lat);
      iload  = mem_word(fa);
      e_ren  = 1'b1;
      e_addr = fa;
      e_hit  = 1'b0;
      e_load = '0;
`ifdef ICACHE_FILL_FWD_EN
      if (!iwait && ren && w == fa) begin
        e_hit  = 1'b1;
        e_load = iload;
      end
`endif
    end else begin
      iwait  = 1'($urandom);
      iload  = $urandom;
      e_ren  = 1'b0;
      e_addr = '0;
      e_hit  = ren && lv[i] && la[i] == w;
      e_load = e_hit ? ld[i] : '0;
    end
    #1;
  endtask

  task automatic advance();
    int i;
    if (busy) begin
      if (!iwait) begin
        i = int'(fa[5:2]);
        lv[i] = 1;
        la[i] = fa;
        ld[i] = iload;
        busy  = 0;
      end else begin
        mcnt++;
      end
    end else if (imemREN && !e_hit) begin
      busy = 1;
      fa   = {imemaddr[31:2], 2'b00};
      mcnt = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = '0; iwait = 1'b0; iload = 32'hdead_beef;
    model_reset();
    #1;
    checks++;
    if (obs() !== 66'd0) begin
      failures++;
      $display("FAIL reset got=%h exp=0", obs());
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_cold_miss();
    int nren = 0;
    logic h4;
    logic [31:0] l4;
    mem_lat = 2;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL cold_miss cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      if (iREN === 1'b1) nren++;
      h4 = ihit; l4 = imemload;
      advance();
    end
    checks++;
    if (nren != 3) begin
      failures++;
      $display("FAIL cold_miss_ren_cycles got=%0d exp=3", nren);
    end
    checks++;
    if ({h4, l4} !== {1'b1, 32'h2008_0001}) begin
      failures++;
      $display("FAIL cold_miss_final got hit=%b load=%h exp hit=1 load=20080001", h4, l4);
    end
  endtask

  task automatic test_warm_hit();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0; addrs[1] = 32'h3;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, addrs[c]);
      checks++;
      if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h2008_0001} || obs() !== expv()) begin
        failures++;
        $display("FAIL warm_hit addr=%h got=%h exp=%h", addrs[c], obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_conflict();
    mem_lat = 1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h40);
      checks++;
      if (obs() !== expv() || (c == 1 && {iREN, iaddr} !== {1'b1, 32'h40})) begin
        failures++;
        $display("FAIL conflict_0x40 cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h0);
      checks++;
      if (obs() !== expv() || (c == 0 && ihit !== 1'b0) || (c == 1 && {iREN, iaddr} !== {1'b1, 32'h0})) begin
        failures++;
        $display("FAIL conflict_0x0 cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, $urandom);
      checks++;
      if (obs() !== expv() || {ihit, iREN} !== 2'b00) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_mid_miss();
    mem_lat = 2;
    drive(1'b1, 32'h10);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h20);
      checks++;
      if (obs() !== expv() || {iREN, iaddr} !== {1'b1, 32'h10}) begin
        failures++;
        $display("FAIL mid_miss_fill cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
    drive(1'b1, 32'h10);
    checks++;
    if (obs() !== expv() || {ihit, imemload} !== {1'b1, mem_word(32'h10)}) begin
      failures++;
      $display("FAIL mid_miss_hit10 got=%h exp=%h", obs(), expv());
    end
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h20);
      checks++;
      if (obs() !== expv() || (c == 0 && ihit !== 1'b0)) begin
        failures++;
        $display("FAIL mid_miss_0x20 cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_miss();
    mem_lat = 5;
    drive(1'b1, 32'h44);
    advance();
    drive(1'b1, 32'h44);
    nRST = 1'b0;
    #1;
    checks++;
    if (obs() !== 66'd0) begin
      failures++;
      $display("FAIL reset_mid_miss got=%h exp=0", obs());
    end
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    mem_lat = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h0);
      checks++;
      if (obs() !== expv() || (c == 0 && ihit !== 1'b0)) begin
        failures++;
        $display("FAIL after_reset_0x0 cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_fwd();
    mem_lat = 1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h8);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL fill_0x8 cyc=%0d got=%h exp=%h", c, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    rand_lat = 1;
    mem_lat  = 1;
    for (int c = 0; c < 400; c++) begin
      a = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      if (c % 50 == 7) a = a | 32'h8000_0000;
      drive($urandom_range(0, 3) != 0, a);
      checks++;
      if (obs() !== expv() || (ihit === 1'b1 && iREN === 1'b1 && !busy)) begin
        failures++;
        $display("FAIL random cyc=%0d addr=%h got=%h exp=%h", c, a, obs(), expv());
      end
      advance();
    end
    rand_lat = 0;
  endtask

  initial begin
    rand_lat = 0;
    mem_lat  = 0;
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_idle();
    test_mid_miss();
    test_reset_mid_miss();
    test_fwd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
